// File: rtl/sw_pkg.sv
// Shared types and defaults for the Smith-Waterman array sequencer and its helpers.
package sw_pkg;

    localparam int DEF_WIDTH     = 10;
    localparam int DEF_LEN_WIDTH = 16;

    localparam logic [1:0] BASE_A = 2'd0;
    localparam logic [1:0] BASE_C = 2'd1;
    localparam logic [1:0] BASE_G = 2'd2;
    localparam logic [1:0] BASE_T = 2'd3;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD_Q,
        ST_STREAM,
        ST_DRAIN,
        ST_DONE
    } sw_state_e;

endpackage

// File: rtl/sw_max_tracker.sv
// Signed running maximum with the position of its first occurrence.
module sw_max_tracker
    import sw_pkg::*;
#(
    parameter int WIDTH     = DEF_WIDTH,
    parameter int POS_WIDTH = DEF_LEN_WIDTH
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    clear,
    input  logic                    sample,
    input  logic signed [WIDTH-1:0] value,
    input  logic [POS_WIDTH-1:0]    pos,
    output logic signed [WIDTH-1:0] best,
    output logic [POS_WIDTH-1:0]    best_pos
);

    // Strict greater-than keeps the earliest position on ties; the floor is 0.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            best     <= '0;
            best_pos <= '0;
        end else if (clear) begin
            best     <= '0;
            best_pos <= '0;
        end else if (sample && (value > best)) begin
            best     <= value;
            best_pos <= pos;
        end
    end

endmodule

// File: rtl/sw_array_seq.sv
// Sequencer for one linear Smith-Waterman PE array: loads the query chain,
// streams the reference, drains the wavefront and reports the best last-PE score.
module sw_array_seq
    import sw_pkg::*;
#(
    parameter int                      NUM_PE    = 64,
    parameter int                      WIDTH     = DEF_WIDTH,
    parameter int                      LEN_WIDTH = DEF_LEN_WIDTH,
    parameter logic signed [WIDTH-1:0] INIT_E    = '0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [LEN_WIDTH-1:0]    ref_len,
    input  logic                    qry_valid,
    output logic                    qry_ready,
    input  logic [1:0]              qry_data,
    input  logic                    ref_valid,
    output logic                    ref_ready,
    input  logic [1:0]              ref_data,
    output logic [1:0]              arr_S,
    output logic                    arr_store_S,
    output logic [1:0]              arr_T,
    output logic                    arr_init,
    output logic signed [WIDTH-1:0] arr_init_V,
    output logic signed [WIDTH-1:0] arr_init_E,
    output logic signed [WIDTH-1:0] arr_init_V_diag,
    input  logic signed [WIDTH-1:0] arr_V_last,
    input  logic                    arr_init_last,
    output logic                    busy,
    output logic                    done,
    output logic signed [WIDTH-1:0] best_score,
    output logic [LEN_WIDTH-1:0]    best_pos,
    output logic                    err_underrun,
    output sw_state_e               dbg_state
);

    localparam int QW = $clog2(NUM_PE + 1);
    localparam int DW = $clog2(NUM_PE + 2);

    sw_state_e            state, state_nxt;
    logic [LEN_WIDTH-1:0] ref_len_q;
    logic [LEN_WIDTH-1:0] ref_cnt;
    logic [LEN_WIDTH-1:0] beat_cnt;
    logic [QW-1:0]        qry_cnt;
    logic [DW-1:0]        drain_cnt;
    logic                 start_acc, qry_acc, ref_acc, underrun, track_en;

    // A beat transfers on a cycle where valid and ready are both high; ready
    // depends only on state, so the host may hold valid without combinational loops.
    always_comb begin
        state_nxt = state;
        qry_ready = 1'b0;
        ref_ready = 1'b0;
        start_acc = 1'b0;
        qry_acc   = 1'b0;
        ref_acc   = 1'b0;
        underrun  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    start_acc = 1'b1;
                    state_nxt = ST_LOAD_Q;
                end
            end
            ST_LOAD_Q: begin
                qry_ready = 1'b1;
                qry_acc   = qry_valid;
                if (qry_valid && (qry_cnt == QW'(NUM_PE - 1)))
                    state_nxt = (ref_len_q == '0) ? ST_DRAIN : ST_STREAM;
            end
            ST_STREAM: begin
                ref_ready = 1'b1;
                ref_acc   = ref_valid;
                underrun  = !ref_valid;
                if (!ref_valid || (ref_cnt == ref_len_q - LEN_WIDTH'(1)))
                    state_nxt = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (drain_cnt == DW'(NUM_PE))
                    state_nxt = ST_DONE;
            end
            ST_DONE: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= ST_IDLE;
        else      state <= state_nxt;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            arr_S        <= '0;
            arr_store_S  <= 1'b0;
            arr_T        <= '0;
            arr_init     <= 1'b0;
            ref_len_q    <= '0;
            ref_cnt      <= '0;
            beat_cnt     <= '0;
            qry_cnt      <= '0;
            drain_cnt    <= '0;
            err_underrun <= 1'b0;
        end else begin
            arr_store_S <= qry_acc;
            arr_init    <= ref_acc;
            if (qry_acc) arr_S <= qry_data;
            if (ref_acc) arr_T <= ref_data;
            if (start_acc) begin
                ref_len_q    <= ref_len;
                ref_cnt      <= '0;
                beat_cnt     <= '0;
                qry_cnt      <= '0;
                drain_cnt    <= '0;
                err_underrun <= 1'b0;
            end else begin
                if (qry_acc && (qry_cnt != QW'(NUM_PE))) qry_cnt <= qry_cnt + QW'(1);
                if (ref_acc)            ref_cnt   <= ref_cnt + LEN_WIDTH'(1);
                if (state == ST_DRAIN)  drain_cnt <= drain_cnt + DW'(1);
                if (track_en)           beat_cnt  <= beat_cnt + LEN_WIDTH'(1);
                if (underrun)           err_underrun <= 1'b1;
            end
        end
    end

    // The last PE emits one result per reference beat, flagged by its init_out.
    assign track_en = ((state == ST_STREAM) || (state == ST_DRAIN)) && arr_init_last;

    sw_max_tracker #(
        .WIDTH     (WIDTH),
        .POS_WIDTH (LEN_WIDTH)
    ) u_max (
        .clk      (clk),
        .rst      (rst),
        .clear    (start_acc),
        .sample   (track_en),
        .value    (arr_V_last),
        .pos      (beat_cnt),
        .best     (best_score),
        .best_pos (best_pos)
    );

    assign arr_init_V      = '0;
    assign arr_init_E      = INIT_E;
    assign arr_init_V_diag = '0;
    assign busy            = (state != ST_IDLE);
    assign done            = (state == ST_DONE);
    assign dbg_state       = state;

endmodule

// File: doc/sw_array_seq.md
Name: sw_array_seq

Overview:
- Sequencer for one linear systolic array of Smith-Waterman PEs, NUM_PE long.
- Shifts a query of NUM_PE bases into the array-level query shift chain, then streams a reference of ref_len bases into the array head with the computation-active flag.
- Drains the wavefront and tracks the best score seen at the last PE.
- Sits between the host-side query/reference stream FIFOs and the PE array wrapper.

Parameters:
- NUM_PE, 64, number of PEs in the array; equals the query length.
- WIDTH, 10, score width; must match the PEs.
- LEN_WIDTH, 16, width of the reference length and position counters.
- INIT_E, 0, value driven on the array init_E while idle; signed WIDTH.

Ports:
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-low
- start  in  1  one-cycle run request; ignored while busy
- ref_len  in  LEN_WIDTH  reference length in bases; latched on an accepted start
- qry_valid / qry_ready  in/out  1  query stream handshake
- qry_data  in  2  query base; encoding A=0, C=1, G=2, T=3
- ref_valid / ref_ready  in/out  1  reference stream handshake
- ref_data  in  2  reference base
- arr_S  out  2  query base into the array query chain
- arr_store_S  out  1  query chain shift enable
- arr_T  out  2  reference base into PE0 T_in
- arr_init  out  1  computation-active into PE0 init_in
- arr_init_V, arr_init_E, arr_init_V_diag  out  WIDTH  init values for PE0: 0, INIT_E, 0; static
- arr_V_last  in  WIDTH  V_out of PE NUM_PE-1
- arr_init_last  in  1  init_out of PE NUM_PE-1
- busy  out  1  high from an accepted start through done
- done  out  1  one-cycle completion pulse
- best_score  out  WIDTH  signed maximum of last-PE V; valid at done, held until next start
- best_pos  out  LEN_WIDTH  last-PE beat index of best_score
- err_underrun  out  1  sticky per run; reference starved during streaming

Behaviour:
- Reset: all outputs 0, except arr_init_E = INIT_E. State IDLE; counters and best values cleared. An asserted reset mid-run aborts the run immediately; no done is generated.
- States: IDLE, LOAD_Q, STREAM, DRAIN, DONE.
- IDLE:
  - start accepted: latch ref_len, clear best_score, best_pos and err_underrun, set busy, go to LOAD_Q.
- LOAD_Q:
  - qry_ready = 1.
  - Each accepted beat registers arr_S = qry_data and arr_store_S = 1 on the next cycle. Latency is 1.
  - If qry_valid is low, arr_store_S = 0 that cycle; the chain holds and no bubble is inserted.
  - Bases arrive in order for PE NUM_PE-1 first.
  - After NUM_PE beats: go to STREAM, or go straight to DRAIN if ref_len == 0.
- STREAM:
  - ref_ready = 1. Each accepted beat registers arr_T = ref_data and arr_init = 1.
  - After ref_len beats: arr_init = 0, go to DRAIN.
  - PEs cannot stall, so ref_valid low in STREAM sets err_underrun, drives arr_init = 0 and moves to DRAIN. The partial results are reported.
- DRAIN:
  - Count NUM_PE+1 cycles after the last arr_init, then go to DONE.
- DONE:
  - done = 1 for one cycle, busy drops, go to IDLE.
  - A start in the same cycle is ignored; the earliest new start is accepted the following cycle.
- Score tracking runs in STREAM and DRAIN:
  - Every cycle with arr_init_last = 1, compare arr_V_last as signed against best_score.
  - On strict greater, update best_score and set best_pos = beat count. The beat count is 0-based and counts arr_init_last cycles.
  - Ties keep the earliest position. Initial best is 0, so an all-negative column reports 0 at position 0.
- Counters:
  - The query counter saturates at NUM_PE.
  - ref_len = 2^LEN_WIDTH-1 is legal; the beat counter must not wrap before the compare.
- qry_ready and ref_ready are 0 in every other state. Stray qry_valid or ref_valid outside its phase is ignored.

Decomposition:
- Package sw_pkg holds:
  - the state enum,
  - base encoding constants,
  - default WIDTH and LEN_WIDTH.
- Sub-module sw_max_tracker: signed running max with position, clear, and sample-enable. It is reused later for multi-array reduction.

Test Plan:
- Basic run, NUM_PE=4, ref_len=6, continuous streams, array model in bench:
  - arr_store_S high 4 cycles with bases in order,
  - then arr_init high exactly 6 cycles,
  - done exactly NUM_PE+1 cycles after the last arr_init,
  - best_score equals the model maximum.
- Query gaps: qry_valid toggled 1,0,1,0,... -> arr_store_S mirrors the accepted beats one cycle later; STREAM entered only after the 4th beat.
- Reference underrun: ref_valid dropped at beat 3 of 6 -> arr_init falls the next cycle, err_underrun = 1, done still pulses, best_score covers beats 0..2 only.
- ref_len = 0 -> LOAD_Q, then DRAIN, then done; arr_init never asserted; best_score = 0, best_pos = 0.
- Tie and negative scores: arr_V_last sequence -1, 5, 5, 3 -> best_score = 5, best_pos = 1. Sequence all -2 -> best_score 0, best_pos 0.
- Reset mid-STREAM (rst low asynchronously between clk edges) -> all outputs at reset values immediately; no done pulse; the next start runs normally. A start during busy is ignored.
